decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter p_WORD_LEN, default 16, instruction/data word width.
REQ-002 SHALL have parameter p_REG_ADDR_LEN, default 3, register address width.
REQ-003 SHALL have port i_clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port i_rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have ports i_instr (input, 16, fetched instruction), i_pc (input, 16, its PC) and i_valid (input, 1, i_instr valid).
REQ-006 SHALL have port i_flush, input, 1, squash from execute (taken BEQ/JALR).
REQ-007 SHALL have port o_stall, input-side, output, 1, fetch holds PC/instr while high.
REQ-008 SHALL have ports o_src1, o_src2, o_tgt, output, 3 each, combinational register-file addresses.
REQ-009 SHALL have ports o_opcode_q (3), o_tgt_q (3), o_src1_q (3), o_src2_q (3), o_imm_q (16), o_pc_q (16), o_wr_en_q (1) and o_valid_q (1), all outputs registered into execute.

Function
REQ-010 Fields SHALL be opcode=[15:13], rA=[12:10], rB=[9:7], rC=[2:0], imm7=[6:0], imm10=[9:0].
REQ-011 ADD/NAND SHALL drive src1=rB, src2=rC, tgt=rA; ADDI/LW/JALR src1=rB, src2=0, tgt=rA; LUI src1=src2=0, tgt=rA; SW src1=rB, src2=rA, tgt=0; BEQ src1=rA, src2=rB, tgt=0.
REQ-012 o_imm_q SHALL be imm7 sign-extended to 16 bits, except LUI: {imm10, 6'b0}.
REQ-013 wr_en SHALL be 1 for ADD, ADDI, NAND, LUI, LW, JALR with rA!=0; else 0.
REQ-014 Registered outputs SHALL appear one cycle after o_src1/o_src2 are presented, aligned with the register file's one-cycle registered read.
REQ-015 Load-use hazard SHALL be: o_valid_q=1, o_opcode_q=LW, o_tgt_q!=0, i_valid=1, and o_tgt_q equals a used, nonzero current source.
REQ-016 On hazard, o_stall SHALL be 1 combinationally, and the next cycle SHALL load a bubble (o_valid_q=0, o_wr_en_q=0, other _q fields don't-care).
REQ-017 A stall SHALL last exactly one cycle, since the bubble removes the LW from the execute register.
REQ-018 If i_valid=0, the next cycle SHALL load a bubble with o_stall=0.
REQ-019 i_flush=1 SHALL load a bubble next cycle, SHALL force o_stall=0, and SHALL take priority over the hazard.
REQ-020 FSM states: RUN (normal advance) and STALL (bubble issued); RUN->STALL on hazard without flush; STALL->RUN unconditionally after one cycle.

Reset
REQ-021 While i_rst_n=0 at posedge: o_valid_q=0, o_wr_en_q=0, all other _q outputs=0, FSM=RUN, and o_stall=0 the following cycle.
REQ-022 Reset mid-stall SHALL abandon the stall; the first instruction after reset SHALL be decoded normally.

Configuration
REQ-023 With DECODE_STALL_CNT_EN defined, output o_stall_cnt (16 bits) SHALL count hazard-stall cycles, saturate at 0xFFFF, exclude flush and i_valid=0 bubbles, and reset to 0.
REQ-024 Without DECODE_STALL_CNT_EN, port o_stall_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 Bench SHALL drive i_instr=0x0503 (ADD r1,r2,r3), valid -> same cycle o_src1=2, o_src2=3, o_tgt=1; next cycle o_valid_q=1, o_wr_en_q=1, o_tgt_q=1.
REQ-026 Bench SHALL drive 0x247F (ADDI r1,r0,-1) -> o_imm_q=0xFFFF; and 0x6BFF (LUI r2,0x3FF) -> o_imm_q=0xFFC0, o_tgt_q=2.
REQ-027 Bench SHALL drive 0xA505 (LW r1,r2,5) then 0x0C84 (ADD r3,r1,r4) -> o_stall=1 for exactly one cycle, one bubble, then ADD issued with o_src1_q=1, o_src2_q=4, and o_stall_cnt=1 when enabled.
REQ-028 Bench SHALL drive LW r0 followed by a reader of r0 -> no stall.
REQ-029 Bench SHALL assert the LW-use pair with i_flush=1 on the hazard cycle -> o_stall=0, bubble next cycle, and o_stall_cnt unchanged.
REQ-030 Bench SHALL assert i_rst_n=0 during the STALL state -> all _q outputs=0 next cycle; after release, 0x0503 decodes per REQ-025.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: register-address decode, immediate formation, load-use stall and flush bubbles.
// Optional hazard-stall counter (o_stall_cnt) is built only when DECODE_STALL_CNT_EN is defined.
`timescale 1ns/1ps
module decode_stage #(
   parameter int p_WORD_LEN     = 16,
   parameter int p_REG_ADDR_LEN = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [p_WORD_LEN-1:0]     i_instr,
   input  logic [p_WORD_LEN-1:0]     i_pc,
   input  logic                      i_valid,
   input  logic                      i_flush,
   output logic                      o_stall,
   output logic [p_REG_ADDR_LEN-1:0] o_src1,
   output logic [p_REG_ADDR_LEN-1:0] o_src2,
   output logic [p_REG_ADDR_LEN-1:0] o_tgt,
   output logic [2:0]                o_opcode_q,
   output logic [p_REG_ADDR_LEN-1:0] o_tgt_q,
   output logic [p_REG_ADDR_LEN-1:0] o_src1_q,
   output logic [p_REG_ADDR_LEN-1:0] o_src2_q,
   output logic [p_WORD_LEN-1:0]     o_imm_q,
   output logic [p_WORD_LEN-1:0]     o_pc_q,
   output logic                      o_wr_en_q,
   output logic                      o_valid_q
`ifdef DECODE_STALL_CNT_EN
   ,
   output logic [15:0]               o_stall_cnt
`endif
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   logic [2:0]                opcode_d;
   logic [p_REG_ADDR_LEN-1:0] ra, rb, rc;
   logic [p_REG_ADDR_LEN-1:0] src1_d, src2_d, tgt_d;
   logic [p_WORD_LEN-1:0]     imm_d;
   logic                      dec_wr_en;
   logic                      wr_en_d, valid_d;
   logic                      hazard, bubble;
   logic [0:0]                state_q, state_d;

   assign opcode_d = i_instr[15:13];
   assign ra       = i_instr[12:10];
   assign rb       = i_instr[9:7];
   assign rc       = i_instr[2:0];

   always_comb begin
      src1_d = '0;
      src2_d = '0;
      tgt_d  = '0;
      case (opcode_d)
         OP_ADD, OP_NAND: begin
            src1_d = rb;
            src2_d = rc;
            tgt_d  = ra;
         end
         OP_ADDI, OP_LW, OP_JALR: begin
            src1_d = rb;
            tgt_d  = ra;
         end
         OP_LUI: tgt_d = ra;
         OP_SW: begin
            src1_d = rb;
            src2_d = ra;
         end
         OP_BEQ: begin
            src1_d = ra;
            src2_d = rb;
         end
         default: ;
      endcase
   end

   always_comb begin
      if (opcode_d == OP_LUI) imm_d = {i_instr[9:0], {(p_WORD_LEN-10){1'b0}}};
      else                    imm_d = {{(p_WORD_LEN-7){i_instr[6]}}, i_instr[6:0]};
   end

   assign dec_wr_en = (opcode_d != OP_SW) && (opcode_d != OP_BEQ) && (ra != '0);

   assign o_src1 = src1_d;
   assign o_src2 = src2_d;
   assign o_tgt  = tgt_d;

   // Unused sources decode to 0, so a nonzero compare also means "source is used".
   always_comb begin
      hazard = (state_q == ST_RUN) && o_valid_q && (o_opcode_q == OP_LW) &&
               (o_tgt_q != '0) && i_valid &&
               (((src1_d != '0) && (src1_d == o_tgt_q)) ||
                ((src2_d != '0) && (src2_d == o_tgt_q)));
      o_stall = hazard && !i_flush;
      bubble  = i_flush || !i_valid || hazard;
      valid_d = !bubble;
      wr_en_d = dec_wr_en && !bubble;
      state_d = o_stall ? ST_STALL : ST_RUN;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= ST_RUN;
         o_opcode_q <= '0;
         o_tgt_q    <= '0;
         o_src1_q   <= '0;
         o_src2_q   <= '0;
         o_imm_q    <= '0;
         o_pc_q     <= '0;
         o_wr_en_q  <= 1'b0;
         o_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         o_opcode_q <= opcode_d;
         o_tgt_q    <= tgt_d;
         o_src1_q   <= src1_d;
         o_src2_q   <= src2_d;
         o_imm_q    <= imm_d;
         o_pc_q     <= i_pc;
         o_wr_en_q  <= wr_en_d;
         o_valid_q  <= valid_d;
      end
   end

`ifdef DECODE_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Only hazard stalls count; flush and idle bubbles never raise o_stall.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (o_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) stall_cnt_q <= '0;
      else          stall_cnt_q <= stall_cnt_d;
   end

   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboarded decode, load-use stall, flush and reset scenarios.
// Define DECODE_STALL_CNT_EN to also check the stall counter.
`timescale 1ns/1ps
module tb_decode_stage;

   typedef struct packed {
      logic        valid;
      logic        wr_en;
      logic [2:0]  op;
      logic [2:0]  tgt;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [15:0] imm;
      logic [15:0] pc;
   } exp_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
      logic        valid;
      logic        flush;
      logic        stall;
      logic        ccmb;
      exp_t        e;
   } stim_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [15:0] i_instr = '0;
   logic [15:0] i_pc = '0;
   logic        i_valid = 1'b0;
   logic        i_flush = 1'b0;
   logic        o_stall;
   logic [2:0]  o_src1, o_src2, o_tgt;
   logic [2:0]  o_opcode_q, o_tgt_q, o_src1_q, o_src2_q;
   logic [15:0] o_imm_q, o_pc_q;
   logic        o_wr_en_q, o_valid_q;
`ifdef DECODE_STALL_CNT_EN
   logic [15:0] o_stall_cnt;
   int          exp_cnt = 0;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   decode_stage dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_instr    (i_instr),
      .i_pc       (i_pc),
      .i_valid    (i_valid),
      .i_flush    (i_flush),
      .o_stall    (o_stall),
      .o_src1     (o_src1),
      .o_src2     (o_src2),
      .o_tgt      (o_tgt),
      .o_opcode_q (o_opcode_q),
      .o_tgt_q    (o_tgt_q),
      .o_src1_q   (o_src1_q),
      .o_src2_q   (o_src2_q),
      .o_imm_q    (o_imm_q),
      .o_pc_q     (o_pc_q),
      .o_wr_en_q  (o_wr_en_q),
      .o_valid_q  (o_valid_q)
`ifdef DECODE_STALL_CNT_EN
      ,
      .o_stall_cnt(o_stall_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   function automatic exp_t observed();
      return {o_valid_q, o_wr_en_q, o_opcode_q, o_tgt_q, o_src1_q, o_src2_q, o_imm_q, o_pc_q};
   endfunction

   // A real instruction: expected decode fields and the registered image one cycle later.
   function automatic stim_t ins(logic [15:0] instr, logic [15:0] pc, logic [2:0] op,
                                 logic [2:0] tgt, logic [2:0] s1, logic [2:0] s2,
                                 logic wr, logic [15:0] imm);
      stim_t s;
      s.instr = instr; s.pc = pc; s.valid = 1'b1; s.flush = 1'b0; s.stall = 1'b0; s.ccmb = 1'b1;
      s.e = {1'b1, wr, op, tgt, s1, s2, imm, pc};
      return s;
   endfunction

   // A cycle whose registered result must be a bubble.
   function automatic stim_t bub(logic [15:0] instr, logic [15:0] pc, logic valid,
                                 logic flush, logic stall);
      stim_t s;
      s.instr = instr; s.pc = pc; s.valid = valid; s.flush = flush; s.stall = stall; s.ccmb = 1'b0;
      s.e = '0;
      return s;
   endfunction

   task automatic test_reset();
      exp_t got;
      i_rst_n = 1'b0; i_instr = 16'hA505; i_pc = 16'hFFFF; i_valid = 1'b1; i_flush = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      got = observed();
      checks++;
      if (got !== '0) begin
         errors++; $display("FAIL reset_regs got=%h exp=%h", got, 46'h0);
      end
      checks++;
      if (o_stall !== 1'b0) begin
         errors++; $display("FAIL reset_stall got=%b exp=0", o_stall);
      end
`ifdef DECODE_STALL_CNT_EN
      checks++;
      if (o_stall_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_cnt got=%0d exp=0", o_stall_cnt);
      end
`endif
      i_rst_n = 1'b1; i_valid = 1'b0;
      @(posedge i_clk); #1;
      checks++;
      if ({o_valid_q, o_wr_en_q, o_stall} !== 3'b000) begin
         errors++; $display("FAIL reset_after got=%b exp=000", {o_valid_q, o_wr_en_q, o_stall});
      end
      $display("txn reset valid_q=%b wr_en_q=%b stall=%b", o_valid_q, o_wr_en_q, o_stall);
   endtask

   task automatic test_decode();
      stim_t t[$];
      exp_t  e, got;
      t.push_back(ins(16'h0503, 16'h0100, 3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0003));
      t.push_back(ins(16'h247F, 16'h0102, 3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF));
      t.push_back(ins(16'h6BFF, 16'h0104, 3'd3, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFC0));
      t.push_back(ins(16'h8505, 16'h0106, 3'd4, 3'd0, 3'd2, 3'd1, 1'b0, 16'h0005));
      t.push_back(ins(16'hC505, 16'h0108, 3'd6, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0005));
      t.push_back(ins(16'hE080, 16'h010A, 3'd7, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0000));
      t.push_back(ins(16'h4E07, 16'h010C, 3'd2, 3'd3, 3'd4, 3'd7, 1'b1, 16'h0007));
      t.push_back(bub(16'h0503, 16'h010E, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < t.size(); k++) begin
         i_instr = t[k].instr; i_pc = t[k].pc; i_valid = t[k].valid; i_flush = t[k].flush;
         #1;
         checks++;
         if (o_stall !== t[k].stall) begin
            errors++; $display("FAIL decode[%0d] stall got=%b exp=%b", k, o_stall, t[k].stall);
         end
         if (t[k].ccmb) begin
            checks++;
            if ({o_tgt, o_src1, o_src2} !== {t[k].e.tgt, t[k].e.s1, t[k].e.s2}) begin
               errors++;
               $display("FAIL decode[%0d] comb tgt/s1/s2 got=%0d/%0d/%0d exp=%0d/%0d/%0d", k,
                        o_tgt, o_src1, o_src2, t[k].e.tgt, t[k].e.s1, t[k].e.s2);
            end
         end
         sb.push_back(t[k].e);
         @(posedge i_clk); #1;
         e = sb.pop_front();
         got = observed();
         checks++;
         if (e.valid ? (got !== e) : ({got.valid, got.wr_en} !== 2'b00)) begin
            errors++; $display("FAIL decode[%0d] regs got=%h exp=%h", k, got, e);
         end
         $display("txn decode[%0d] instr=%h valid_q=%b wr_q=%b op=%0d tgt=%0d s1=%0d s2=%0d imm=%h pc=%h",
                  k, t[k].instr, got.valid, got.wr_en, got.op, got.tgt, got.s1, got.s2, got.imm, got.pc);
      end
   endtask

   task automatic test_load_use();
      stim_t t[$];
      exp_t  e, got;
      t.push_back(ins(16'hA505, 16'h0200, 3'd5, 3'd1, 3'd2, 3'd0, 1'b1, 16'h0005));
      t.push_back(bub(16'h0C84, 16'h0202, 1'b1, 1'b0, 1'b1));
      t.push_back(ins(16'h0C84, 16'h0202, 3'd0, 3'd3, 3'd1, 3'd4, 1'b1, 16'h0004));
      t.push_back(ins(16'hA105, 16'h0204, 3'd5, 3'd0, 3'd2, 3'd0, 1'b0, 16'h0005));
      t.push_back(ins(16'h0400, 16'h0206, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0000));
      t.push_back(ins(16'hA505, 16'h0208, 3'd5, 3'd1, 3'd2, 3'd0, 1'b1, 16'h0005));
      t.push_back(ins(16'h4E07, 16'h020A, 3'd2, 3'd3, 3'd4, 3'd7, 1'b1, 16'h0007));
      t.push_back(ins(16'hA505, 16'h020C, 3'd5, 3'd1, 3'd2, 3'd0, 1'b1, 16'h0005));
      t.push_back(bub(16'h8505, 16'h020E, 1'b1, 1'b0, 1'b1));
      t.push_back(ins(16'h8505, 16'h020E, 3'd4, 3'd0, 3'd2, 3'd1, 1'b0, 16'h0005));
      t.push_back(ins(16'hA505, 16'h0210, 3'd5, 3'd1, 3'd2, 3'd0, 1'b1, 16'h0005));
      t.push_back(bub(16'h0C84, 16'h0212, 1'b1, 1'b1, 1'b0));
      t.push_back(bub(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < t.size(); k++) begin
         i_instr = t[k].instr; i_pc = t[k].pc; i_valid = t[k].valid; i_flush = t[k].flush;
         #1;
         checks++;
         if (o_stall !== t[k].stall) begin
            errors++; $display("FAIL load_use[%0d] stall got=%b exp=%b", k, o_stall, t[k].stall);
         end
         if (t[k].ccmb) begin
            checks++;
            if ({o_tgt, o_src1, o_src2} !== {t[k].e.tgt, t[k].e.s1, t[k].e.s2}) begin
               errors++;
               $display("FAIL load_use[%0d] comb tgt/s1/s2 got=%0d/%0d/%0d exp=%0d/%0d/%0d", k,
                        o_tgt, o_src1, o_src2, t[k].e.tgt, t[k].e.s1, t[k].e.s2);
            end
         end
         sb.push_back(t[k].e);
         @(posedge i_clk); #1;
`ifdef DECODE_STALL_CNT_EN
         if (t[k].stall) exp_cnt++;
         checks++;
         if (o_stall_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL load_use[%0d] stall_cnt got=%0d exp=%0d", k, o_stall_cnt, exp_cnt);
         end
`endif
         e = sb.pop_front();
         got = observed();
         checks++;
         if (e.valid ? (got !== e) : ({got.valid, got.wr_en} !== 2'b00)) begin
            errors++; $display("FAIL load_use[%0d] regs got=%h exp=%h", k, got, e);
         end
         $display("txn load_use[%0d] instr=%h flush=%b stall=%b valid_q=%b wr_q=%b op=%0d s1=%0d s2=%0d pc=%h",
                  k, t[k].instr, t[k].flush, t[k].stall, got.valid, got.wr_en, got.op, got.s1, got.s2, got.pc);
      end
   endtask

   task automatic test_reset_mid_stall();
      exp_t e, got;
      i_instr = 16'hA505; i_pc = 16'h0300; i_valid = 1'b1; i_flush = 1'b0;
      #1;
      sb.push_back({1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 3'd0, 16'h0005, 16'h0300});
      @(posedge i_clk); #1;
      e = sb.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
         errors++; $display("FAIL rst_stall lw regs got=%h exp=%h", got, e);
      end
      i_instr = 16'h0C84; i_pc = 16'h0302;
      #1;
      checks++;
      if (o_stall !== 1'b1) begin
         errors++; $display("FAIL rst_stall hazard got=%b exp=1", o_stall);
      end
      @(posedge i_clk); #1;
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      got = observed();
      checks++;
      if (got !== '0) begin
         errors++; $display("FAIL rst_stall regs got=%h exp=%h", got, 46'h0);
      end
      checks++;
      if (o_stall !== 1'b0) begin
         errors++; $display("FAIL rst_stall stall got=%b exp=0", o_stall);
      end
`ifdef DECODE_STALL_CNT_EN
      exp_cnt = 0;
      checks++;
      if (o_stall_cnt !== 16'(exp_cnt)) begin
         errors++; $display("FAIL rst_stall cnt got=%0d exp=%0d", o_stall_cnt, exp_cnt);
      end
`endif
      $display("txn rst_stall reset valid_q=%b stall=%b", o_valid_q, o_stall);
      i_rst_n = 1'b1; i_instr = 16'h0503; i_pc = 16'h0400; i_valid = 1'b1;
      #1;
      checks++;
      if ({o_stall, o_src1, o_src2, o_tgt} !== {1'b0, 3'd2, 3'd3, 3'd1}) begin
         errors++;
         $display("FAIL rst_stall add comb got=%b/%0d/%0d/%0d exp=0/2/3/1", o_stall, o_src1, o_src2, o_tgt);
      end
      sb.push_back({1'b1, 1'b1, 3'd0, 3'd1, 3'd2, 3'd3, 16'h0003, 16'h0400});
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      e = sb.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
         errors++; $display("FAIL rst_stall add regs got=%h exp=%h", got, e);
      end
      $display("txn rst_stall add valid_q=%b wr_q=%b tgt=%0d pc=%h", got.valid, got.wr_en, got.tgt, got.pc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_decode();
      test_load_use();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
